// File: rtl/reg_bus_bridge_pkg.sv
// ---------------------------------------------------------------------------
// reg_bus_bridge_pkg
//   Shared definitions for the register-bus bridge: FSM state encoding,
//   default bus widths and the read-wait counter sizing.
// ---------------------------------------------------------------------------
package reg_bus_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam int DEF_ADDR_WIDTH  = 33;
  localparam int DEF_WDATA_WIDTH = 33;
  localparam int DEF_RDATA_WIDTH = 21;

  // The read-wait counter must reach READ_WAIT_MAX, so it needs CNT_W bits.
  localparam int READ_WAIT_MAX = 15;
  localparam int CNT_W         = 4;

endpackage

// File: rtl/reg_bridge_cmd_fifo.sv
// ---------------------------------------------------------------------------
// reg_bridge_cmd_fifo
//   Synchronous command FIFO placed in front of the bridge FSM. It is only
//   instantiated when REG_BRIDGE_CMD_FIFO_EN is defined.
//   Ports:
//     clock, reset        single clock, synchronous active-low reset
//     push_i, push_data_i write side; a push while full is ignored
//     pop_i, pop_data_o   read side; pop_data_o shows the head entry
//     full_o, empty_o     occupancy flags
//   DEPTH must be a power of two so that the pointers wrap naturally.
// ---------------------------------------------------------------------------
module reg_bridge_cmd_fifo
  import reg_bus_bridge_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == (PTR_W + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

  // NOTE: the storage array is deliberately not reset; entries are only
  // read after being written, and leaving it unreset lets it map to RAM.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign pop_data_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/reg_bus_bridge.sv
// ---------------------------------------------------------------------------
// reg_bus_bridge
//   Upstream master for the control-register block. Accepts single-beat
//   read/write commands on a valid/ready channel, drives the register
//   block strobes, and returns one in-order response per command.
//   Ports:
//     clock, reset                  single clock, synchronous active-low reset
//     cmd_valid/cmd_ready           command handshake
//     cmd_write/cmd_addr/cmd_wdata  command payload
//     rsp_valid/rsp_ready           response handshake
//     rsp_write/rsp_rdata           response payload (rdata is 0 for writes)
//     address/write_data            held access address and payload
//     write_enable/read_enable      register block strobes
//     read_data                     combinational read data from the block
//     busy                          FSM not idle (or command queue occupied)
//   Build option: define REG_BRIDGE_CMD_FIFO_EN to insert a FIFO_DEPTH-entry
//   command FIFO so commands are accepted while an access is in flight.
// ---------------------------------------------------------------------------
module reg_bus_bridge
  import reg_bus_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int WDATA_WIDTH = DEF_WDATA_WIDTH,
  parameter int RDATA_WIDTH = DEF_RDATA_WIDTH,
  parameter int READ_WAIT   = 0,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [ADDR_WIDTH-1:0]  cmd_addr,
  input  logic [WDATA_WIDTH-1:0] cmd_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_write,
  output logic [RDATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0]  address,
  output logic                   write_enable,
  output logic [WDATA_WIDTH-1:0] write_data,
  output logic                   read_enable,
  input  logic [RDATA_WIDTH-1:0] read_data,
  output logic                   busy
);

  // Elaboration-time parameter sanity checks.
  if (READ_WAIT < 0 || READ_WAIT > READ_WAIT_MAX) begin : g_bad_read_wait
    $error("reg_bus_bridge: READ_WAIT must be in 0..15");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("reg_bus_bridge: FIFO_DEPTH must be a power of two >= 2");
  end

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(READ_WAIT);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       wait_q, wait_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [WDATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [RDATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                   rsp_write_q, rsp_write_d;

  // Command source seen by the FSM: either the port directly or the FIFO head.
  logic                   src_valid;
  logic                   src_write;
  logic [ADDR_WIDTH-1:0]  src_addr;
  logic [WDATA_WIDTH-1:0] src_wdata;
  logic                   queue_busy;

`ifdef REG_BRIDGE_CMD_FIFO_EN
  localparam int ENTRY_W = 1 + ADDR_WIDTH + WDATA_WIDTH;

  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;
  logic [ENTRY_W-1:0] fifo_head;

  // The FSM consumes the head entry on the cycle it leaves IDLE.
  assign fifo_pop = (state_q == ST_IDLE) && !fifo_empty;

  reg_bridge_cmd_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (cmd_valid),
    .push_data_i ({cmd_write, cmd_addr, cmd_wdata}),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign cmd_ready                        = !fifo_full;
  assign src_valid                        = !fifo_empty;
  assign {src_write, src_addr, src_wdata} = fifo_head;
  assign queue_busy                       = !fifo_empty;
`else
  assign cmd_ready  = (state_q == ST_IDLE);
  assign src_valid  = cmd_valid;
  assign src_write  = cmd_write;
  assign src_addr   = cmd_addr;
  assign src_wdata  = cmd_wdata;
  assign queue_busy = 1'b0;
`endif

  // NOTE: every signal driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    rsp_write_d = rsp_write_q;
    unique case (state_q)
      ST_IDLE: begin
        if (src_valid) begin
          addr_d  = src_addr;
          wdata_d = src_wdata;
          wait_d  = '0;
          state_d = src_write ? ST_WRITE : ST_READ;
        end
      end
      ST_WRITE: begin
        rsp_write_d = 1'b1;
        rdata_d     = '0;
        state_d     = ST_RESP;
      end
      ST_READ: begin
        // read_enable stays high until the counter reaches READ_WAIT; the
        // data is captured on that final strobe cycle.
        if (wait_q == WAIT_LAST) begin
          rdata_d     = read_data;
          rsp_write_d = 1'b0;
          state_d     = ST_RESP;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      wait_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rsp_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      rsp_write_q <= rsp_write_d;
    end
  end

  // Strobes decode straight from the state register: glitch-free, mutually
  // exclusive, and dropped by the same edge that applies reset.
  assign write_enable = (state_q == ST_WRITE);
  assign read_enable  = (state_q == ST_READ);
  assign rsp_valid    = (state_q == ST_RESP);
  assign rsp_write    = rsp_write_q;
  assign rsp_rdata    = rdata_q;
  assign address      = addr_q;
  assign write_data   = wdata_q;
  assign busy         = (state_q != ST_IDLE) || queue_busy;

endmodule

// File: tb/tb_reg_bus_bridge.sv
// ---------------------------------------------------------------------------
// tb_reg_bus_bridge
//   Directed self-checking bench for reg_bus_bridge (READ_WAIT=3,
//   FIFO_DEPTH=2). The register block is a combinational stub returning
//   0x0ABCD at address 0x55 and 0x1F00F elsewhere. Inputs change and
//   outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_reg_bus_bridge;

  localparam int AW    = 33;
  localparam int WW    = 33;
  localparam int RW    = 21;
  localparam int RWAIT = 3;
  localparam int DEPTH = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr  = '0;
  logic [WW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic          rsp_write;
  logic [RW-1:0] rsp_rdata;
  logic [AW-1:0] address;
  logic          write_enable;
  logic [WW-1:0] write_data;
  logic          read_enable;
  logic [RW-1:0] read_data;
  logic          busy;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  assign read_data = (address == 33'h55) ? 21'h0ABCD : 21'h1F00F;

  reg_bus_bridge #(
    .ADDR_WIDTH  (AW),
    .WDATA_WIDTH (WW),
    .RDATA_WIDTH (RW),
    .READ_WAIT   (RWAIT),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_write    (rsp_write),
    .rsp_rdata    (rsp_rdata),
    .address      (address),
    .write_enable (write_enable),
    .write_data   (write_data),
    .read_enable  (read_enable),
    .read_data    (read_data),
    .busy         (busy)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic wr, input logic [AW-1:0] a, input logic [WW-1:0] d);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
  endtask

  // Present a command, let it be accepted, and return in the first cycle of
  // the access (the FIFO build spends one extra cycle queueing it).
  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [WW-1:0] d);
    send(wr, a, d);
    tick();
    cmd_valid = 1'b0;
`ifdef REG_BRIDGE_CMD_FIFO_EN
    tick();
`endif
  endtask

  // Called in the first READ cycle: expects 4 strobe cycles, then the response.
  task automatic read_access(input string tag, input logic [AW-1:0] a, input logic [RW-1:0] exp);
    for (int i = 0; i < RWAIT + 1; i++) begin
      check({tag, "_ren"}, read_enable, 1);
      check({tag, "_wen"}, write_enable, 0);
      check({tag, "_addr"}, address, a);
      check({tag, "_rvalid_early"}, rsp_valid, 0);
      tick();
    end
    check({tag, "_ren_off"}, read_enable, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 1);
    check({tag, "_rsp_write"}, rsp_write, 0);
    check({tag, "_rsp_rdata"}, rsp_rdata, exp);
    tick();
    check({tag, "_rsp_drop"}, rsp_valid, 0);
    check({tag, "_idle"}, busy, 0);
  endtask

`ifdef REG_BRIDGE_CMD_FIFO_EN
  logic [AW-1:0] we_addr[$];
  logic [WW-1:0] we_data[$];
  int            accepted;
  int            responses;
  bit            full_seen;
  bit            hs;
`else
  bit            seen_rsp;
`endif

  initial begin
    // ---- reset state ----
    reset = 1'b0;
    tick();
    tick();
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_wen", write_enable, 0);
    check("rst_ren", read_enable, 0);
    check("rst_busy", busy, 0);
    check("rst_addr", address, 0);
    check("rst_wdata", write_data, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_rsp_write", rsp_write, 0);
    reset = 1'b1;

    // ---- write 0xAA <- 0x1234 ----
    issue(1'b1, 33'hAA, 33'h1234);
    check("wr_wen", write_enable, 1);
    check("wr_ren", read_enable, 0);
    check("wr_addr", address, 33'hAA);
    check("wr_wdata", write_data, 33'h1234);
    check("wr_rsp_early", rsp_valid, 0);
    check("wr_busy", busy, 1);
`ifndef REG_BRIDGE_CMD_FIFO_EN
    check("wr_cmd_ready", cmd_ready, 0);
`endif
    tick();
    check("wr_wen_once", write_enable, 0);
    check("wr_rsp_valid", rsp_valid, 1);
    check("wr_rsp_write", rsp_write, 1);
    check("wr_rsp_rdata", rsp_rdata, 0);
    tick();
    check("wr_rsp_drop", rsp_valid, 0);
    check("wr_cmd_ready_back", cmd_ready, 1);
    check("wr_busy_off", busy, 0);

    // ---- 20 idle cycles: strobes low, address held ----
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_wen", write_enable, 0);
      check("idle_ren", read_enable, 0);
      check("idle_addr", address, 33'hAA);
    end

    // ---- read 0x55 with READ_WAIT=3 ----
    issue(1'b0, 33'h55, 33'h0);
    read_access("rd", 33'h55, 21'h0ABCD);

`ifndef REG_BRIDGE_CMD_FIFO_EN
    // ---- backpressure: response held for 10 cycles, cmd_valid kept high ----
    rsp_ready = 1'b0;
    send(1'b1, 33'h10, 33'h77);
    tick();
    send(1'b0, 33'h55, 33'h0);      // next command waits behind the stall
    check("bp_wen", write_enable, 1);
    tick();
    for (int i = 0; i < 10; i++) begin
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_write", rsp_write, 1);
      check("bp_rsp_rdata", rsp_rdata, 0);
      check("bp_cmd_ready", cmd_ready, 0);
      check("bp_addr", address, 33'h10);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    check("bp_released", rsp_valid, 0);
    check("bp_ready_back", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    read_access("bp_rd", 33'h55, 21'h0ABCD);
`endif

    // ---- reset during the second READ cycle ----
    issue(1'b0, 33'h66, 33'h0);
    tick();
    check("mid_ren_c2", read_enable, 1);
    reset = 1'b0;
    tick();
    check("mid_ren", read_enable, 0);
    check("mid_busy", busy, 0);
    check("mid_rsp_valid", rsp_valid, 0);
    check("mid_cmd_ready", cmd_ready, 1);
    check("mid_addr", address, 0);
    reset = 1'b1;
`ifndef REG_BRIDGE_CMD_FIFO_EN
    seen_rsp = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rsp_valid) seen_rsp = 1'b1;
    end
    check("mid_no_rsp", seen_rsp, 0);
`endif
    // A fresh read must see the full strobe length (wait counter cleared).
    issue(1'b0, 33'h55, 33'h0);
    read_access("post_rst", 33'h55, 21'h0ABCD);

`ifdef REG_BRIDGE_CMD_FIFO_EN
    // ---- 4 back-to-back writes through a 2-entry FIFO ----
    accepted  = 0;
    responses = 0;
    full_seen = 1'b0;
    send(1'b1, 33'h1, 33'h101);
    for (int c = 0; c < 60 && responses < 4; c++) begin
      if (cmd_valid && !cmd_ready && !full_seen) begin
        full_seen = 1'b1;
        check("fifo_full_accepted", accepted, 3);
        check("fifo_full_rsp", responses, 0);
      end
      if (write_enable) begin
        we_addr.push_back(address);
        we_data.push_back(write_data);
      end
      if (rsp_valid && rsp_ready) begin
        responses++;
        check("fifo_rsp_write", rsp_write, 1);
        check("fifo_rsp_rdata", rsp_rdata, 0);
      end
      hs = cmd_valid && cmd_ready;
      tick();
      if (hs) begin
        accepted++;
        if (accepted < 4) send(1'b1, AW'(accepted + 1), WW'(32'h101 + accepted));
        else cmd_valid = 1'b0;
      end
    end
    check("fifo_full_seen", full_seen, 1);
    check("fifo_rsp_count", responses, 4);
    check("fifo_pulse_count", we_addr.size(), 4);
    for (int i = 0; i < 4 && i < we_addr.size(); i++) begin
      check("fifo_we_addr", we_addr[i], 64'(i + 1));
      check("fifo_we_data", we_data[i], 64'(32'h101 + i));
    end
    tick();
    check("fifo_drained", busy, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
